// File: rtl/call_frame_ctrl_if.sv
// Bundle between the execute stage, call_frame_ctrl and SuperStack.
// The slave modport is the controller; master is the surrounding pipeline.
interface call_frame_ctrl_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned FRAMES = 4
);
  localparam int unsigned FDW = $clog2(FRAMES) + 1;

  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [1:0]       cmd;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [DEPTH:0]   nargs;
  logic             nresults;
  logic             done;
  logic             error;
  logic [1:0]       err_code;
  logic [FDW-1:0]   frame_depth;
  logic [2:0]       stk_op;
  logic [WIDTH-1:0] stk_data;
  logic [DEPTH:0]   stk_limit;
  logic [DEPTH:0]   stk_index;
  logic [WIDTH-1:0] stk_tos;
  logic [2:0]       stk_status;

  modport master (
    output in_op, in_data, cmd, cmd_valid, nargs, nresults,
           stk_index, stk_tos, stk_status,
    input  in_ready, cmd_ready, done, error, err_code, frame_depth,
           stk_op, stk_data, stk_limit
  );

  modport slave (
    input  in_op, in_data, cmd, cmd_valid, nargs, nresults,
           stk_index, stk_tos, stk_status,
    output in_ready, cmd_ready, done, error, err_code, frame_depth,
           stk_op, stk_data, stk_limit
  );
endinterface

// File: rtl/call_frame_ctrl.sv
// Call-frame controller in front of SuperStack: fences callee arguments on CALL,
// unwinds the frame and re-pushes the result on RETURN.
module call_frame_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned FRAMES = 4
) (
  input logic              clk,
  input logic              reset,
  call_frame_ctrl_if.slave bus
);
  localparam int unsigned FB  = $clog2(FRAMES);
  localparam int unsigned FDW = FB + 1;

  localparam logic [2:0] OP_NONE            = 3'd0;
  localparam logic [2:0] OP_PUSH            = 3'd1;
  localparam logic [2:0] OP_UNDERFLOW_RESET = 3'd4;

  localparam logic [1:0] CMD_CALL = 2'd1;
  localparam logic [1:0] CMD_RET  = 2'd2;

  localparam logic [1:0] ERR_FRAME_OVF   = 2'd1;
  localparam logic [1:0] ERR_FRAME_UNDER = 2'd2;
  localparam logic [1:0] ERR_ARG_UNDER   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RET_DROP,
    S_RET_RESTORE,
    S_RET_PUSH
  } state_e;

  state_e           state_q, state_d;
  logic [DEPTH:0]   limit_q, limit_d;
  logic [FDW-1:0]   depth_q, depth_d;
  logic [DEPTH:0]   lifo_q [FRAMES];
  logic [DEPTH:0]   lifo_d [FRAMES];
  logic [WIDTH-1:0] result_q, result_d;
  logic             nres_q, nres_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [1:0]       err_code_q, err_code_d;

  logic             cmd_accept;
  logic [DEPTH:0]   avail;
  logic [FB-1:0]    push_idx;
  logic [FB-1:0]    pop_idx;
  logic             err_hit;
  logic [1:0]       err_val;

  assign cmd_accept = bus.cmd_valid && (bus.cmd == CMD_CALL || bus.cmd == CMD_RET);
  assign avail      = bus.stk_index - limit_q;
  assign push_idx   = depth_q[FB-1:0];
  assign pop_idx    = FB'(depth_q - FDW'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      limit_q    <= '0;
      depth_q    <= '0;
      result_q   <= '0;
      nres_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= '0;
      for (int unsigned i = 0; i < FRAMES; i++) lifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      depth_q    <= depth_d;
      result_q   <= result_d;
      nres_q     <= nres_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      lifo_q     <= lifo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    depth_d    = depth_q;
    lifo_d     = lifo_q;
    result_d   = result_q;
    nres_d     = nres_q;
    done_d     = 1'b0;
    error_d    = error_q;
    err_code_d = err_code_q;
    err_hit    = 1'b0;
    err_val    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && bus.cmd == CMD_CALL) begin
          if (depth_q == FDW'(FRAMES)) begin
            err_hit = 1'b1;
            err_val = ERR_FRAME_OVF;
          end else if (bus.nargs > avail) begin
            err_hit = 1'b1;
            err_val = ERR_ARG_UNDER;
          end else begin
            lifo_d[push_idx] = limit_q;
            limit_d          = bus.stk_index - bus.nargs;
            depth_d          = depth_q + FDW'(1);
            done_d           = 1'b1;
          end
        end else if (bus.cmd_valid && bus.cmd == CMD_RET) begin
          if (depth_q == '0) begin
            err_hit = 1'b1;
            err_val = ERR_FRAME_UNDER;
          end else if (bus.nresults && bus.stk_index == limit_q) begin
            err_hit = 1'b1;
            err_val = ERR_ARG_UNDER;
          end else begin
            // TOS is current here because SuperStack is idle during IDLE accepts.
            result_d = bus.stk_tos;
            nres_d   = bus.nresults;
            state_d  = S_RET_DROP;
          end
        end
      end
      S_RET_DROP: state_d = S_RET_RESTORE;
      S_RET_RESTORE: begin
        limit_d = lifo_q[pop_idx];
        depth_d = depth_q - FDW'(1);
        if (nres_q) begin
          state_d = S_RET_PUSH;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_RET_PUSH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (err_hit) begin
      error_d = 1'b1;
      if (!error_q) err_code_d = err_val;
    end
  end

  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.stk_op    = OP_NONE;
    bus.stk_data  = bus.in_data;
    unique case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.stk_op    = cmd_accept ? OP_NONE : bus.in_op;
      end
      S_RET_DROP:    bus.stk_op = OP_UNDERFLOW_RESET;
      S_RET_RESTORE: bus.stk_op = OP_NONE;
      S_RET_PUSH: begin
        bus.stk_op   = OP_PUSH;
        bus.stk_data = result_q;
      end
      default: bus.stk_op = OP_NONE;
    endcase
  end

  assign bus.in_ready    = bus.cmd_ready;
  assign bus.stk_limit   = limit_q;
  assign bus.frame_depth = depth_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.err_code    = err_code_q;
endmodule

// File: tb/tb_call_frame_ctrl.sv
// Directed bench for call_frame_ctrl against a small behavioural SuperStack.
module tb_call_frame_ctrl;
  localparam logic [2:0] OP_NONE = 3'd0, OP_PUSH = 3'd1, OP_POP = 3'd2,
                         OP_REPLACE = 3'd3, OP_UNDERFLOW_RESET = 3'd4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_pass = 0;
  int push_cnt = 0;

  always #5 clk = ~clk;

  call_frame_ctrl_if #(.WIDTH(8), .DEPTH(3), .FRAMES(4)) bus ();
  call_frame_ctrl #(.WIDTH(8), .DEPTH(3), .FRAMES(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Behavioural SuperStack: registered ops, index = entry count.
  logic [7:0] mem [8];
  logic [3:0] s_idx;
  always @(posedge clk) begin
    if (!reset) s_idx <= 4'd0;
    else begin
      case (bus.stk_op)
        OP_PUSH: if (s_idx < 4'd8) begin mem[s_idx[2:0]] <= bus.stk_data; s_idx <= s_idx + 4'd1; end
        OP_POP: if (s_idx > bus.stk_limit) s_idx <= s_idx - 4'd1;
        OP_REPLACE: if (s_idx != 4'd0) mem[s_idx[2:0] - 3'd1] <= bus.stk_data;
        OP_UNDERFLOW_RESET: s_idx <= bus.stk_limit;
        default: ;
      endcase
    end
    if (bus.stk_op == OP_PUSH) push_cnt <= push_cnt + 1;
  end
  assign bus.stk_index  = s_idx;
  assign bus.stk_tos    = (s_idx == 4'd0) ? 8'h00 : mem[s_idx[2:0] - 3'd1];
  assign bus.stk_status = 3'd0;

  task automatic do_op(input logic [2:0] op, input logic [7:0] d);
    bus.in_op = op; bus.in_data = d;
    @(negedge clk);
    bus.in_op = OP_NONE;
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [3:0] na, input logic nr);
    bus.cmd = c; bus.cmd_valid = 1'b1; bus.nargs = na; bus.nresults = nr;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd = 2'd0;
  endtask

  task automatic wait_ready(output int busy);
    busy = 0;
    while (bus.cmd_ready !== 1'b1 && busy < 10) begin
      busy++;
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_ready: got %0b expected 1", bus.cmd_ready); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b expected 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.stk_limit !== 4'd0) $display("FAIL rst_limit: got %0d expected 0", bus.stk_limit); else n_pass++;
    n_checks++; if (bus.frame_depth !== 3'd0) $display("FAIL rst_depth: got %0d expected 0", bus.frame_depth); else n_pass++;
    n_checks++; if (bus.error !== 1'b0) $display("FAIL rst_error: got %0b expected 0", bus.error); else n_pass++;
    n_checks++; if (bus.err_code !== 2'd0) $display("FAIL rst_err_code: got %0d expected 0", bus.err_code); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %0b expected 0", bus.done); else n_pass++;
    bus.in_op = OP_PUSH; bus.in_data = 8'd5;
    #1;
    n_checks++; if (bus.stk_op !== OP_PUSH) $display("FAIL rst_fwd_op: got %0d expected %0d", bus.stk_op, OP_PUSH); else n_pass++;
    n_checks++; if (bus.stk_data !== 8'd5) $display("FAIL rst_fwd_data: got %0d expected 5", bus.stk_data); else n_pass++;
    bus.in_op = OP_NONE; bus.in_data = 8'd0;
  endtask

  task automatic test_call_return();
    int busy;
    do_op(OP_PUSH, 8'd5); do_op(OP_PUSH, 8'd6); do_op(OP_PUSH, 8'd7);
    do_cmd(2'd1, 4'd2, 1'b0);
    n_checks++; if (bus.stk_limit !== 4'd1) $display("FAIL call_limit: got %0d expected 1", bus.stk_limit); else n_pass++;
    n_checks++; if (bus.frame_depth !== 3'd1) $display("FAIL call_depth: got %0d expected 1", bus.frame_depth); else n_pass++;
    n_checks++; if (bus.done !== 1'b1) $display("FAIL call_done: got %0b expected 1", bus.done); else n_pass++;
    n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL call_ready: got %0b expected 1", bus.cmd_ready); else n_pass++;
    do_op(OP_PUSH, 8'd9);
    n_checks++; if (bus.done !== 1'b0) $display("FAIL call_done_pulse: got %0b expected 0", bus.done); else n_pass++;
    do_cmd(2'd2, 4'd0, 1'b1);
    n_checks++; if (bus.stk_op !== OP_UNDERFLOW_RESET) $display("FAIL ret_drop_op: got %0d expected %0d", bus.stk_op, OP_UNDERFLOW_RESET); else n_pass++;
    wait_ready(busy);
    n_checks++; if (busy !== 3) $display("FAIL ret_busy: got %0d expected 3", busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b1) $display("FAIL ret_done: got %0b expected 1", bus.done); else n_pass++;
    n_checks++; if (bus.stk_limit !== 4'd0) $display("FAIL ret_limit: got %0d expected 0", bus.stk_limit); else n_pass++;
    n_checks++; if (bus.frame_depth !== 3'd0) $display("FAIL ret_depth: got %0d expected 0", bus.frame_depth); else n_pass++;
    n_checks++; if (bus.stk_index !== 4'd2) $display("FAIL ret_index: got %0d expected 2", bus.stk_index); else n_pass++;
    n_checks++; if (bus.stk_tos !== 8'd9) $display("FAIL ret_tos: got %0d expected 9", bus.stk_tos); else n_pass++;
  endtask

  task automatic test_return_no_result();
    int busy, p0;
    do_op(OP_PUSH, 8'd6);
    do_cmd(2'd1, 4'd2, 1'b0);
    n_checks++; if (bus.stk_limit !== 4'd1) $display("FAIL nr_call_limit: got %0d expected 1", bus.stk_limit); else n_pass++;
    p0 = push_cnt;
    do_cmd(2'd2, 4'd0, 1'b0);
    wait_ready(busy);
    n_checks++; if (busy !== 2) $display("FAIL nr_busy: got %0d expected 2", busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b1) $display("FAIL nr_done: got %0b expected 1", bus.done); else n_pass++;
    n_checks++; if (bus.stk_index !== 4'd1) $display("FAIL nr_index: got %0d expected 1", bus.stk_index); else n_pass++;
    n_checks++; if (bus.stk_tos !== 8'd5) $display("FAIL nr_tos: got %0d expected 5", bus.stk_tos); else n_pass++;
    n_checks++; if (bus.stk_limit !== 4'd0) $display("FAIL nr_limit: got %0d expected 0", bus.stk_limit); else n_pass++;
    n_checks++; if (push_cnt !== p0) $display("FAIL nr_no_push: got %0d pushes expected 0", push_cnt - p0); else n_pass++;
  endtask

  task automatic test_nesting();
    int busy;
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      do_op(OP_PUSH, 8'(i));
      do_cmd(2'd1, 4'd0, 1'b0);
      n_checks++; if (bus.stk_limit !== 4'(i)) $display("FAIL nest_limit_%0d: got %0d expected %0d", i, bus.stk_limit, i); else n_pass++;
    end
    n_checks++; if (bus.frame_depth !== 3'd4) $display("FAIL nest_depth: got %0d expected 4", bus.frame_depth); else n_pass++;
    do_cmd(2'd1, 4'd0, 1'b0);
    n_checks++; if (bus.error !== 1'b1) $display("FAIL ovf_error: got %0b expected 1", bus.error); else n_pass++;
    n_checks++; if (bus.err_code !== 2'd1) $display("FAIL ovf_code: got %0d expected 1", bus.err_code); else n_pass++;
    n_checks++; if (bus.stk_limit !== 4'd4) $display("FAIL ovf_limit: got %0d expected 4", bus.stk_limit); else n_pass++;
    n_checks++; if (bus.frame_depth !== 3'd4) $display("FAIL ovf_depth: got %0d expected 4", bus.frame_depth); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL ovf_done: got %0b expected 0", bus.done); else n_pass++;
    for (int i = 3; i >= 0; i--) begin
      do_cmd(2'd2, 4'd0, 1'b0);
      wait_ready(busy);
      n_checks++; if (bus.stk_limit !== 4'(i)) $display("FAIL unwind_limit_%0d: got %0d expected %0d", i, bus.stk_limit, i); else n_pass++;
      n_checks++; if (bus.frame_depth !== 3'(i)) $display("FAIL unwind_depth_%0d: got %0d expected %0d", i, bus.frame_depth, i); else n_pass++;
    end
  endtask

  task automatic test_error_codes();
    int p0;
    apply_reset();
    p0 = push_cnt;
    bus.in_op = OP_PUSH; bus.in_data = 8'h33;
    bus.cmd = 2'd2; bus.cmd_valid = 1'b1; bus.nresults = 1'b0;
    #1;
    n_checks++; if (bus.stk_op !== OP_NONE) $display("FAIL under_op: got %0d expected %0d", bus.stk_op, OP_NONE); else n_pass++;
    @(negedge clk);
    bus.in_op = OP_NONE; bus.cmd_valid = 1'b0; bus.cmd = 2'd0;
    n_checks++; if (bus.error !== 1'b1) $display("FAIL under_error: got %0b expected 1", bus.error); else n_pass++;
    n_checks++; if (bus.err_code !== 2'd2) $display("FAIL under_code: got %0d expected 2", bus.err_code); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL under_done: got %0b expected 0", bus.done); else n_pass++;
    n_checks++; if (push_cnt !== p0) $display("FAIL under_dropped_push: got %0d pushes expected 0", push_cnt - p0); else n_pass++;
    apply_reset();
    n_checks++; if (bus.error !== 1'b0) $display("FAIL err_cleared: got %0b expected 0", bus.error); else n_pass++;
    do_op(OP_PUSH, 8'd1); do_op(OP_PUSH, 8'd2); do_op(OP_PUSH, 8'd3);
    do_cmd(2'd1, 4'd4, 1'b0);
    n_checks++; if (bus.err_code !== 2'd3) $display("FAIL arg_code: got %0d expected 3", bus.err_code); else n_pass++;
    n_checks++; if (bus.stk_limit !== 4'd0) $display("FAIL arg_limit: got %0d expected 0", bus.stk_limit); else n_pass++;
    n_checks++; if (bus.frame_depth !== 3'd0) $display("FAIL arg_depth: got %0d expected 0", bus.frame_depth); else n_pass++;
    do_cmd(2'd2, 4'd0, 1'b0);
    n_checks++; if (bus.err_code !== 2'd3) $display("FAIL second_err_code: got %0d expected 3", bus.err_code); else n_pass++;
    do_cmd(2'd1, 4'd3, 1'b0);
    n_checks++; if (bus.frame_depth !== 3'd1) $display("FAIL edge_call_depth: got %0d expected 1", bus.frame_depth); else n_pass++;
    n_checks++; if (bus.done !== 1'b1) $display("FAIL edge_call_done: got %0b expected 1", bus.done); else n_pass++;
    do_cmd(2'd1, 4'd0, 1'b0);
    n_checks++; if (bus.stk_limit !== 4'd3) $display("FAIL empty_call_limit: got %0d expected 3", bus.stk_limit); else n_pass++;
    do_cmd(2'd2, 4'd0, 1'b1);
    n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL res_under_ready: got %0b expected 1", bus.cmd_ready); else n_pass++;
    n_checks++; if (bus.frame_depth !== 3'd2) $display("FAIL res_under_depth: got %0d expected 2", bus.frame_depth); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL res_under_done: got %0b expected 0", bus.done); else n_pass++;
  endtask

  task automatic test_reset_mid_return();
    int p0;
    apply_reset();
    do_op(OP_PUSH, 8'd1); do_cmd(2'd1, 4'd0, 1'b0);
    do_op(OP_PUSH, 8'd2); do_cmd(2'd1, 4'd0, 1'b0);
    do_op(OP_PUSH, 8'd3);
    n_checks++; if (bus.frame_depth !== 3'd2) $display("FAIL mid_setup_depth: got %0d expected 2", bus.frame_depth); else n_pass++;
    p0 = push_cnt;
    do_cmd(2'd2, 4'd0, 1'b1);
    @(negedge clk);
    n_checks++; if (bus.cmd_ready !== 1'b0) $display("FAIL mid_busy: got %0b expected 0", bus.cmd_ready); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL mid_idle: got %0b expected 1", bus.cmd_ready); else n_pass++;
    n_checks++; if (bus.stk_limit !== 4'd0) $display("FAIL mid_limit: got %0d expected 0", bus.stk_limit); else n_pass++;
    n_checks++; if (bus.frame_depth !== 3'd0) $display("FAIL mid_depth: got %0d expected 0", bus.frame_depth); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL mid_done: got %0b expected 0", bus.done); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0) $display("FAIL mid_done_after: got %0b expected 0", bus.done); else n_pass++;
    n_checks++; if (push_cnt !== p0) $display("FAIL mid_no_push: got %0d pushes expected 0", push_cnt - p0); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_op = OP_NONE; bus.in_data = 8'd0;
    bus.cmd = 2'd0; bus.cmd_valid = 1'b0; bus.nargs = 4'd0; bus.nresults = 1'b0;
    @(negedge clk);
    test_reset();
    test_call_return();
    test_return_no_result();
    test_nesting();
    test_error_codes();
    test_reset_mid_return();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
